fm_tile_issuer: RTL and testbench
=================================

# fm_tile_issuer

Issues feature-map tiles to the systolic-array controller. Per tile it waits for the input buffer to hold a complete tile, pulses `re_fm_en`, and streams `nif_mult_k_mult_k + 1` consecutive buffer reads in lock-step with the controller's pixel counter. It then holds off the next tile until the controller reports that tile's quantify stage has drained (`quantify_add_end`). It sits between the feature-map buffer and the SA controller, on the transmitting side of the `re_fm_en` / `quantify_add_end` exchange.

## Interface
Parameters:
- `ADDR_W`, 16: feature-map buffer address width.
- `TILE_W`, 16: tile-count width.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-low; reset taken when `reset==0` at a rising edge.
- `start`  in  1  one-cycle job start; ignored unless idle.
- `tile_num`  in  TILE_W  tiles in job; sampled on accepted `start`.
- `nif_mult_k_mult_k`  in  32  words per tile minus one; sampled on accepted `start`.
- `fm_base_addr`  in  ADDR_W  address of tile 0 word 0; sampled on accepted `start`.
- `fm_tile_valid`  in  1  buffer holds a complete next tile (level).
- `fm_tile_consume`  out  1  one-cycle pulse: current tile fully read, buffer may free it.
- `fm_rd_en`  out  1  buffer read strobe.
- `fm_rd_addr`  out  ADDR_W  buffer read address.
- `re_fm_en`  out  1  one-cycle pulse to SA controller on the first word of each tile.
- `quantify_add_end`  in  1  pulse from SA controller: tile output complete.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at job end.
- `proto_err`  out  1  sticky; set by `quantify_add_end` outside DRAIN.

## Operation
- All outputs are registered. Reset value of every output is 0. Internal counters and captured parameters reset to 0 and the state resets to IDLE.
- Let N = captured `nif_mult_k_mult_k`. A tile has N+1 words.
- Address rule: word i of tile t is read from `fm_base_addr + t*(N+1) + i`. Keep a running address register that increments once per word and carries across tiles; no multiplier. The address wraps modulo 2^ADDR_W.
- State machine:
  - IDLE: on `start`, capture the parameters and set `busy=1`. If `tile_num==0`, go to FIN. Otherwise go to WAIT_FM.
  - WAIT_FM: when `fm_tile_valid==1`, go to ISSUE.
  - ISSUE: count words i = 0..N. `fm_rd_en=1` every cycle in this state. `re_fm_en=1` only when i==0. After word N, go to DRAIN.
  - DRAIN: `fm_tile_consume=1` on the first DRAIN cycle only. On `quantify_add_end`: increment the tile index, then go to FIN if it was the last tile, otherwise to WAIT_FM.
  - FIN: for one cycle, `done=1` and `busy=0`. Then go to IDLE.
- `start` while busy is ignored; no parameters are recaptured.
- `quantify_add_end` in any state other than DRAIN is ignored for sequencing and sets `proto_err`. `proto_err` clears only on reset.
- `fm_tile_valid` is sampled only in WAIT_FM. Deassertion during ISSUE has no effect, because a tile is only issued when complete.
- N=0 gives a one-word tile: `re_fm_en` and `fm_rd_en` are both high for one cycle.
- Reset mid-tile: all outputs return to 0 on the next edge. There is no partial `done` and no `fm_tile_consume` pulse.

## Timing
- `start` sampled at edge t: `busy` is high from t+1.
- In WAIT_FM, `fm_tile_valid` sampled high at edge e: `re_fm_en` and the first `fm_rd_en` are high in the cycle following e.
- ISSUE lasts exactly N+1 cycles. `fm_rd_en` is contiguous and exactly covers the SA controller's pixel-count window.
- `fm_tile_consume` is high in the cycle immediately after the last `fm_rd_en`.
- `quantify_add_end` sampled at edge q:
  - not last tile: state is WAIT_FM from q+1, so the earliest next `re_fm_en` is in the cycle after q+1.
  - last tile: `done` is high in cycle q+1 to q+2, and `busy` is low from q+1.
- Buffer read latency belongs to the consumer. This block only guarantees that `fm_rd_en` and `fm_rd_addr` are aligned with each other.

## Structure
- Shared package: state enum (IDLE, WAIT_FM, ISSUE, DRAIN, FIN), `FM_ADDR_W`, `TILE_W`, and the 32-bit count width used by the SA controller's `nif_mult_k_mult_k`.
- One natural sub-module: `fm_word_counter`, which holds the word index, the running address and the last-word flag.
- The FSM and handshake outputs live in the top.

## Test plan
- **Single tile.** `tile_num=1`, N=8, base=0x100, `fm_tile_valid=1` → one `re_fm_en` pulse; 9 contiguous reads at 0x100–0x108; `fm_tile_consume` in the next cycle. `quantify_add_end` 40 cycles later → `done` one cycle later, `busy` low.
- **Multi-tile addressing.** `tile_num=3`, N=3, base=0 → reads 0..3, 4..7, 8..11; 3 `re_fm_en` pulses; each tile starts only after the prior `quantify_add_end`.
- **Boundaries.** Case 1: `tile_num=0` → `done` at t+2, no reads. Case 2: N=0, `tile_num=2` → per tile `re_fm_en` and `fm_rd_en` are high together for one cycle.
- **Back-pressure and wrap.**
  - `fm_tile_valid` low for 10 cycles after `start`: no reads until it rises, then `re_fm_en` follows one cycle later.
  - base=0xFFFE, N=3: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Protocol errors.** Case 1: `quantify_add_end` during ISSUE → `proto_err=1` and the sequence is unchanged. Case 2: `start` during DRAIN → ignored, parameters unchanged.
- **Reset mid-operation.** `reset=0` during word 5 of N=8 → all outputs 0 next cycle. A new `start` afterwards runs normally from the new base.

Source files
------------

// File: rtl/fm_tile_issuer_pkg.sv
// Shared types and widths for the feature-map tile issuer.
package fm_tile_issuer_pkg;

  localparam int unsigned FM_ADDR_W = 16;
  localparam int unsigned TILE_W    = 16;
  localparam int unsigned NIF_W     = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_FM = 3'd1,
    ISSUE   = 3'd2,
    DRAIN   = 3'd3,
    FIN     = 3'd4
  } state_t;

endpackage

// File: rtl/fm_tile_issuer_word.sv
// Word index and running buffer address for tile streaming.
// The address carries across tiles so no per-tile multiply is needed.
module fm_word_counter #(
  parameter int unsigned ADDR_W = fm_tile_issuer_pkg::FM_ADDR_W,
  parameter int unsigned CNT_W  = fm_tile_issuer_pkg::NIF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              step,
  input  logic [CNT_W-1:0]  n_words_m1,
  output logic [ADDR_W-1:0] addr,
  output logic              last_word_c
);

  logic [CNT_W-1:0] word_idx;

  assign last_word_c = (word_idx == n_words_m1);

  // Index wraps to zero after the last word; address keeps counting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_idx <= '0;
      addr     <= '0;
    end else if (load) begin
      word_idx <= '0;
      addr     <= base_addr;
    end else if (step) begin
      word_idx <= last_word_c ? '0 : word_idx + CNT_W'(1);
      addr     <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fm_tile_issuer.sv
// Issues feature-map tiles to the SA controller: waits for a full tile,
// streams N+1 reads with a re_fm_en pulse, then waits for quantify drain.
module fm_tile_issuer #(
  parameter int unsigned ADDR_W = fm_tile_issuer_pkg::FM_ADDR_W,
  parameter int unsigned TILE_W = fm_tile_issuer_pkg::TILE_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [TILE_W-1:0]                    tile_num,
  input  logic [fm_tile_issuer_pkg::NIF_W-1:0] nif_mult_k_mult_k,
  input  logic [ADDR_W-1:0]                    fm_base_addr,
  input  logic                                 fm_tile_valid,
  output logic                                 fm_tile_consume,
  output logic                                 fm_rd_en,
  output logic [ADDR_W-1:0]                    fm_rd_addr,
  output logic                                 re_fm_en,
  input  logic                                 quantify_add_end,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 proto_err
);

  import fm_tile_issuer_pkg::*;

  state_t            state, state_nxt;
  logic [TILE_W-1:0] tile_num_q;
  logic [TILE_W-1:0] tile_idx, tile_idx_nxt;
  logic [NIF_W-1:0]  n_q;
  logic              load_c, step_c, last_word_c, last_tile_c;
  logic              busy_nxt, done_nxt, re_nxt, rd_en_nxt, consume_nxt, proto_err_nxt;

  fm_word_counter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (NIF_W)
  ) u_word (
    .clk         (clk),
    .reset       (reset),
    .load        (load_c),
    .base_addr   (fm_base_addr),
    .step        (step_c),
    .n_words_m1  (n_q),
    .addr        (fm_rd_addr),
    .last_word_c (last_word_c)
  );

  assign last_tile_c = ((tile_idx + TILE_W'(1)) == tile_num_q);

  // Next state and look-ahead outputs, so registered outputs line up with the state.
  always_comb begin
    state_nxt     = state;
    tile_idx_nxt  = tile_idx;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    re_nxt        = 1'b0;
    rd_en_nxt     = 1'b0;
    consume_nxt   = 1'b0;
    load_c        = 1'b0;
    step_c        = 1'b0;
    proto_err_nxt = proto_err | (quantify_add_end && (state != DRAIN));
    case (state)
      IDLE: begin
        if (start) begin
          load_c       = 1'b1;
          busy_nxt     = 1'b1;
          tile_idx_nxt = '0;
          state_nxt    = (tile_num == '0) ? FIN : WAIT_FM;
        end
      end
      WAIT_FM: begin
        if (fm_tile_valid) begin
          state_nxt = ISSUE;
          re_nxt    = 1'b1;
          rd_en_nxt = 1'b1;
        end
      end
      ISSUE: begin
        step_c = 1'b1;
        if (last_word_c) begin
          state_nxt   = DRAIN;
          consume_nxt = 1'b1;
        end else begin
          rd_en_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (quantify_add_end) begin
          tile_idx_nxt = tile_idx + TILE_W'(1);
          state_nxt    = last_tile_c ? FIN : WAIT_FM;
        end
      end
      FIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      tile_num_q      <= '0;
      tile_idx        <= '0;
      n_q             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      re_fm_en        <= 1'b0;
      fm_rd_en        <= 1'b0;
      fm_tile_consume <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      state           <= state_nxt;
      tile_idx        <= tile_idx_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      re_fm_en        <= re_nxt;
      fm_rd_en        <= rd_en_nxt;
      fm_tile_consume <= consume_nxt;
      proto_err       <= proto_err_nxt;
      if (load_c) begin
        tile_num_q <= tile_num;
        n_q        <= nif_mult_k_mult_k;
      end
    end
  end

endmodule

// File: tb/tb_fm_tile_issuer.sv
// Directed self-checking bench for fm_tile_issuer.
module tb_fm_tile_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] tile_num;
  logic [31:0] nif_mult_k_mult_k;
  logic [15:0] fm_base_addr;
  logic        fm_tile_valid;
  logic        fm_tile_consume;
  logic        fm_rd_en;
  logic [15:0] fm_rd_addr;
  logic        re_fm_en;
  logic        quantify_add_end;
  logic        busy;
  logic        done;
  logic        proto_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fm_tile_issuer #(.ADDR_W(16), .TILE_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .tile_num          (tile_num),
    .nif_mult_k_mult_k (nif_mult_k_mult_k),
    .fm_base_addr      (fm_base_addr),
    .fm_tile_valid     (fm_tile_valid),
    .fm_tile_consume   (fm_tile_consume),
    .fm_rd_en          (fm_rd_en),
    .fm_rd_addr        (fm_rd_addr),
    .re_fm_en          (re_fm_en),
    .quantify_add_end  (quantify_add_end),
    .busy              (busy),
    .done              (done),
    .proto_err         (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] tn, input logic [31:0] n, input logic [15:0] base);
    tile_num          = tn;
    nif_mult_k_mult_k = n;
    fm_base_addr      = base;
    start             = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_quantify();
    quantify_add_end = 1'b1;
    tick();
    quantify_add_end = 1'b0;
  endtask

  // Waits for re_fm_en, then checks the whole contiguous read burst and the consume pulse.
  task automatic run_tile(input logic [15:0] base, input int n, input int qerr_at);
    int          early;
    bit          seen;
    logic [15:0] a;
    early = 0;
    seen  = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      if (re_fm_en) seen = 1'b1;
      else if (fm_rd_en) early++;
    end
    check("re_fm_en_seen", 32'(seen), 32'd1);
    check("reads_before_re", 32'(early), 32'd0);
    if (seen) begin
      for (int k = 0; k <= n; k++) begin
        if (k > 0) tick();
        quantify_add_end = 1'b0;
        a = base + 16'(k);
        check("rd_en", 32'(fm_rd_en), 32'd1);
        check("rd_addr", 32'(fm_rd_addr), 32'(a));
        check("re_fm_en_word", 32'(re_fm_en), 32'(k == 0));
        check("consume_in_issue", 32'(fm_tile_consume), 32'd0);
        if (k == qerr_at) quantify_add_end = 1'b1;
      end
      tick();
      quantify_add_end = 1'b0;
      check("rd_en_after", 32'(fm_rd_en), 32'd0);
      check("consume", 32'(fm_tile_consume), 32'd1);
      tick();
      check("consume_once", 32'(fm_tile_consume), 32'd0);
    end
  endtask

  // Last-tile quantify: FIN for one cycle, then done with busy low.
  task automatic finish_job();
    pulse_quantify();
    check("done_early", 32'(done), 32'd0);
    tick();
    check("done", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    tick();
    check("done_once", 32'(done), 32'd0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int rd;
    rd = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (fm_rd_en || re_fm_en) rd++;
    end
    check(tag, 32'(rd), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    tile_num = '0;
    nif_mult_k_mult_k = '0;
    fm_base_addr = '0;
    fm_tile_valid = 1'b0;
    quantify_add_end = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(fm_rd_en), 32'd0);
    check("rst_addr", 32'(fm_rd_addr), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    reset = 1'b1;
    tick();

    // Single tile, N=8 at 0x100, long drain
    fm_tile_valid = 1'b1;
    start_job(16'd1, 32'd8, 16'h0100);
    check("busy_after_start", 32'(busy), 32'd1);
    run_tile(16'h0100, 8, -1);
    quiet(40, "drain_quiet");
    check("busy_in_drain", 32'(busy), 32'd1);
    finish_job();

    // Three tiles, N=3, base 0: carried addressing
    start_job(16'd3, 32'd3, 16'h0000);
    for (int t = 0; t < 3; t++) begin
      run_tile(16'(4 * t), 3, -1);
      if (t < 2) begin
        quiet(5, "hold_until_quantify");
        pulse_quantify();
      end
    end
    finish_job();

    // tile_num = 0: done with no reads
    start_job(16'd0, 32'd5, 16'h0500);
    check("t0_rd_en", 32'(fm_rd_en), 32'd0);
    tick();
    check("t0_done", 32'(done), 32'd1);
    check("t0_busy", 32'(busy), 32'd0);
    check("t0_rd_en2", 32'(fm_rd_en), 32'd0);
    tick();

    // N = 0, two single-word tiles
    start_job(16'd2, 32'd0, 16'h0020);
    run_tile(16'h0020, 0, -1);
    pulse_quantify();
    run_tile(16'h0021, 0, -1);
    finish_job();

    // Back-pressure then address wrap
    fm_tile_valid = 1'b0;
    start_job(16'd1, 32'd3, 16'hFFFE);
    quiet(10, "no_read_without_valid");
    fm_tile_valid = 1'b1;
    run_tile(16'hFFFE, 3, -1);
    finish_job();

    // quantify during ISSUE flags an error; start during DRAIN is ignored
    start_job(16'd2, 32'd8, 16'h0300);
    run_tile(16'h0300, 8, 3);
    check("proto_err_set", 32'(proto_err), 32'd1);
    start_job(16'd1, 32'd1, 16'h0900);
    pulse_quantify();
    run_tile(16'h0309, 8, -1);
    finish_job();
    check("proto_err_sticky", 32'(proto_err), 32'd1);

    // Reset during word 5 of N=8
    start_job(16'd1, 32'd8, 16'h0040);
    for (int c = 0; c < 50 && !re_fm_en; c++) tick();
    repeat (5) tick();
    check("pre_reset_addr", 32'(fm_rd_addr), 32'h0045);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_rd_en", 32'(fm_rd_en), 32'd0);
    check("mid_rst_addr", 32'(fm_rd_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_consume", 32'(fm_tile_consume), 32'd0);
    check("mid_rst_perr", 32'(proto_err), 32'd0);
    tick();
    check("post_rst_done", 32'(done), 32'd0);
    start_job(16'd1, 32'd2, 16'h0080);
    run_tile(16'h0080, 2, -1);
    finish_job();
    check("final_perr", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
